// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: control codes, FSM encoding,
// and the small combinational helpers used by the grant and masking logic.
package riscv_alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } arb_state_t;

  // Returns 1 when requester 1 wins; prio names the requester favoured on a tie.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic prio);
    return (v0 && v1) ? prio : v1;
  endfunction

  function automatic logic ctrl_legal(input logic [ALU_CTRL_W-1:0] c);
    return (c == ALU_AND) || (c == ALU_OR) || (c == ALU_ADD) || (c == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// 64-bit RISC-V ALU subset (AND/OR/ADD/SUB). Unknown codes yield 0; wraparound
// arithmetic, carry and borrow are discarded.
module alu_share_arbiter_alu
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic [WIDTH-1:0]  X,
  input  logic [WIDTH-1:0]  Y,
  input  logic [CTRL_W-1:0] ALUControl,
  output logic [WIDTH-1:0]  ALUResult,
  output logic              Zero
);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_AND: ALUResult = X & Y;
      ALU_OR:  ALUResult = X | Y;
      ALU_ADD: ALUResult = X + Y;
      ALU_SUB: ALUResult = X - Y;
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; each
// operation walks IDLE -> EXEC -> RESP and the result is held until consumed.
module alu_share_arbiter
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid0,
  input  logic              ReqValid1,
  output logic              ReqReady0,
  output logic              ReqReady1,
  input  logic [WIDTH-1:0]  ReqX0,
  input  logic [WIDTH-1:0]  ReqX1,
  input  logic [WIDTH-1:0]  ReqY0,
  input  logic [WIDTH-1:0]  ReqY1,
  input  logic [CTRL_W-1:0] ReqCtrl0,
  input  logic [CTRL_W-1:0] ReqCtrl1,
  output logic              RspValid0,
  output logic              RspValid1,
  input  logic              RspReady0,
  input  logic              RspReady1,
  output logic [WIDTH-1:0]  RspResult,
  output logic              RspZero,
  output logic [31:0]       OpCount,
  output logic [1:0]        dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready are
  // both high; requesters hold valid and payload stable until they see ready.

  arb_state_t        state_q, state_d;
  logic              prio_q, prio_d;
  logic              grant_q, grant_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [31:0]       op_count_q, op_count_d;

  logic              pick;
  logic              rsp_taken;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  alu_share_arbiter_alu #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .X          (x_q),
    .Y          (y_q),
    .ALUControl (ctrl_q),
    .ALUResult  (alu_result),
    .Zero       (alu_zero)
  );

  assign pick      = rr_pick(ReqValid0, ReqValid1, prio_q);
  assign rsp_taken = grant_q ? RspReady1 : RspReady0;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    x_d          = x_q;
    y_d          = y_q;
    ctrl_d       = ctrl_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    op_count_d   = op_count_q;
    ReqReady0    = 1'b0;
    ReqReady1    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready is gated by rst_n so nothing looks accepted while held in reset.
        if (rst_n && (ReqValid0 || ReqValid1)) begin
          ReqReady0 = ~pick;
          ReqReady1 = pick;
          grant_d   = pick;
          x_d       = pick ? ReqX1 : ReqX0;
          y_d       = pick ? ReqY1 : ReqY0;
          ctrl_d    = pick ? ReqCtrl1 : ReqCtrl0;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_legal(ctrl_q)) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
        end else begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_taken) begin
          op_count_d = op_count_q + 32'd1;
          prio_d     = ~grant_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      grant_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      ctrl_q       <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      grant_q      <= grant_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ctrl_q       <= ctrl_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  assign RspValid0 = rst_n && (state_q == S_RESP) && !grant_q;
  assign RspValid1 = rst_n && (state_q == S_RESP) && grant_q;
  assign RspResult = rsp_result_q;
  assign RspZero   = rsp_zero_q;
  assign OpCount   = op_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a vector table of single-requester ops plus
// hand-written sequences for arbitration, backpressure and mid-operation reset.
module tb_alu_share_arbiter;
  import riscv_alu_pkg::*;

  localparam int W = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic         ReqReady0, ReqReady1;
  logic [W-1:0] ReqX0 = '0, ReqX1 = '0, ReqY0 = '0, ReqY1 = '0;
  logic [3:0]   ReqCtrl0 = '0, ReqCtrl1 = '0;
  logic         RspValid0, RspValid1;
  logic         RspReady0 = 1'b0, RspReady1 = 1'b0;
  logic [W-1:0] RspResult;
  logic         RspZero;
  logic [31:0]  OpCount;
  logic [1:0]   dbg_state;

  alu_share_arbiter #(.WIDTH(W), .CTRL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReqValid0 (ReqValid0),
    .ReqValid1 (ReqValid1),
    .ReqReady0 (ReqReady0),
    .ReqReady1 (ReqReady1),
    .ReqX0     (ReqX0),
    .ReqX1     (ReqX1),
    .ReqY0     (ReqY0),
    .ReqY1     (ReqY1),
    .ReqCtrl0  (ReqCtrl0),
    .ReqCtrl1  (ReqCtrl1),
    .RspValid0 (RspValid0),
    .RspValid1 (RspValid1),
    .RspReady0 (RspReady0),
    .RspReady1 (RspReady1),
    .RspResult (RspResult),
    .RspZero   (RspZero),
    .OpCount   (OpCount),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         sel;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   ctrl;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic sel, input logic v, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [3:0] c);
    if (sel) begin
      ReqValid1 = v; ReqX1 = x; ReqY1 = y; ReqCtrl1 = c;
    end else begin
      ReqValid0 = v; ReqX0 = x; ReqY0 = y; ReqCtrl0 = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    RspReady0 = 1'b0;
    RspReady1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int n;
    logic [W-1:0] e;
    @(negedge clk);
    RspReady0 = ~v.sel;
    RspReady1 = v.sel;
    drive_req(v.sel, 1'b1, v.x, v.y, v.ctrl);
    exp_q.push_back(v.exp_res);
    #1;
    n = 0;
    while (!(v.sel ? ReqReady1 : ReqReady0) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    if (!(v.sel ? ReqReady1 : ReqReady0)) begin
      checks++; errors++;
      $display("FAIL v%0d_ready_timeout: got ready=0 expected ready=1 within 10 cycles", idx);
      drive_req(v.sel, 1'b0, '0, '0, '0);
      void'(exp_q.pop_front());
      return;
    end
    check($sformatf("v%0d_other_ready", idx), v.sel ? ReqReady0 : ReqReady1, 0);
    @(posedge clk); #1;
    drive_req(v.sel, 1'b0, '0, '0, '0);
    @(negedge clk);
    check($sformatf("v%0d_exec_rspvalid", idx), v.sel ? RspValid1 : RspValid0, 0);
    @(negedge clk);
    check($sformatf("v%0d_rspvalid", idx), v.sel ? RspValid1 : RspValid0, 1);
    check($sformatf("v%0d_other_rspvalid", idx), v.sel ? RspValid0 : RspValid1, 0);
    e = exp_q.pop_front();
    check($sformatf("v%0d_result", idx), RspResult, e);
    check($sformatf("v%0d_zero", idx), RspZero, v.exp_zero);
    exp_count++;
    @(negedge clk);
    check($sformatf("v%0d_opcount", idx), OpCount, exp_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 64'd7, 64'd4, ALU_AND, 64'd4, 1'b0};
    vecs[1] = '{1'b1, 64'd15, 64'd18, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[2] = '{1'b0, 64'd7, 64'd8, ALU_OR, 64'd15, 1'b0};
    vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, 1'b1};
    vecs[4] = '{1'b1, 64'd123, 64'd45, 4'b1111, 64'd0, 1'b1};
    vecs[5] = '{1'b0, 64'd0, 64'd1, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 64'hF0F0, 64'h0F0F, ALU_AND, 64'd0, 1'b1};
    vecs[7] = '{1'b1, 64'hA5, 64'h5A, 4'b0011, 64'd0, 1'b1};

    // reset state, with a request pending that must not be accepted
    rst_n = 1'b0;
    ReqValid0 = 1'b1; ReqX0 = 64'd1; ReqY0 = 64'd2; ReqCtrl0 = ALU_ADD;
    repeat (2) @(negedge clk);
    #1;
    check("rst_reqready0", ReqReady0, 0);
    check("rst_rspvalid0", RspValid0, 0);
    check("rst_rspvalid1", RspValid1, 0);
    check("rst_result", RspResult, 0);
    check("rst_zero", RspZero, 0);
    check("rst_opcount", OpCount, 0);
    check("rst_state", dbg_state, S_IDLE);
    ReqValid0 = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(vecs[i], i);

    // both requesters valid every cycle: grants alternate 0,1,0,1
    do_reset();
    RspReady0 = 1'b1; RspReady1 = 1'b1;
    drive_req(1'b0, 1'b1, 64'd5, 64'd5, ALU_SUB);
    drive_req(1'b1, 1'b1, 64'd10, 64'd23, ALU_ADD);
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = i[0];
      #1;
      check($sformatf("rr%0d_ready0", i), ReqReady0, !g);
      check($sformatf("rr%0d_ready1", i), ReqReady1, g);
      exp_q.push_back(g ? 64'd33 : 64'd0);
      @(negedge clk);
      @(negedge clk); #1;
      check($sformatf("rr%0d_rspvalid", i), g ? RspValid1 : RspValid0, 1);
      check($sformatf("rr%0d_result", i), RspResult, exp_q.pop_front());
      check($sformatf("rr%0d_zero", i), RspZero, !g);
      exp_count++;
      @(negedge clk);
    end
    drive_req(1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    #1;
    check("rr_opcount", OpCount, exp_count);

    // backpressure on requester 0 while requester 1 waits
    RspReady0 = 1'b0; RspReady1 = 1'b1;
    drive_req(1'b0, 1'b1, 64'd7, 64'd8, ALU_OR);
    drive_req(1'b1, 1'b1, 64'd1, 64'd1, ALU_ADD);
    #1;
    check("bp_ready0", ReqReady0, 1);
    check("bp_ready1", ReqReady1, 0);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    check("bp_exec_ready1", ReqReady1, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("bp%0d_rspvalid0", k), RspValid0, 1);
      check($sformatf("bp%0d_result", k), RspResult, 64'd15);
      check($sformatf("bp%0d_zero", k), RspZero, 0);
      check($sformatf("bp%0d_ready1", k), ReqReady1, 0);
    end
    RspReady0 = 1'b1;
    exp_count++;
    @(negedge clk); #1;
    check("bp_release_rspvalid0", RspValid0, 0);
    check("bp_release_ready1", ReqReady1, 1);
    check("bp_release_opcount", OpCount, exp_count);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk); #1;
    check("bp_req1_rspvalid1", RspValid1, 1);
    check("bp_req1_result", RspResult, 64'd2);
    exp_count++;
    @(negedge clk); #1;
    check("bp_req1_opcount", OpCount, exp_count);

    // reset while in EXEC: op discarded, then a re-issued op completes
    do_reset();
    RspReady0 = 1'b1;
    drive_req(1'b0, 1'b1, 64'd3, 64'd4, ALU_ADD);
    #1;
    check("mr_ready0", ReqReady0, 1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("mr_state", dbg_state, S_IDLE);
    check("mr_rspvalid0", RspValid0, 0);
    check("mr_rspvalid1", RspValid1, 0);
    check("mr_opcount", OpCount, exp_count);
    run_op('{1'b0, 64'd3, 64'd4, ALU_ADD, 64'd7, 1'b0}, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
